// File: rtl/ntt_butterfly_unified.sv
// Radix-2 NTT/INTT butterfly with one fully pipelined Barrett multiplier.
// CT (mode=0): a = A + wB, b = A - wB.  GS (mode=1): a = A + B, b = (A - B)w.
// Optional halving (multiply by 2^-1 mod Q) on both outputs.
//
// Both modes use the multiplier in the same pipeline slots (stages 3-6), so an
// operation of either mode can follow any other on the next cycle. GS does its
// add/sub in stage 2 ahead of the multiplier. CT passes B and A through stage 2
// unchanged, and its add/sub runs in front of the halving logic in stage 7.
// Latency is 7 + EXTRA_PIPE enabled cycles in both modes.
module ntt_butterfly_unified #(
    parameter int          WIDTH      = 30,
    parameter int unsigned Q          = 998244353,
    parameter int          EXTRA_PIPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             mode,
    input  logic             halve,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] w,
    output logic             out_valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    localparam logic [WIDTH+1:0]   QX      = (WIDTH+2)'(Q);
    localparam logic [2*WIDTH:0]   POW2    = {1'b1, {(2*WIDTH){1'b0}}};
    localparam logic [2*WIDTH:0]   MU_FULL = POW2 / (2*WIDTH+1)'(Q);
    localparam logic [WIDTH:0]     MU      = MU_FULL[WIDTH:0];

    // x + y mod Q for x, y < Q
    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX[WIDTH:0]) begin
            s = s - QX[WIDTH:0];
        end else begin
            s = s;
        end
        return s[WIDTH-1:0];
    endfunction

    // x - y mod Q for x, y < Q; the W-bit wrap cancels when Q is added back
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x - y;
        if (x < y) begin
            d = d + QX[WIDTH-1:0];
        end else begin
            d = d;
        end
        return d;
    endfunction

    // x * 2^-1 mod Q: odd values are made even by adding Q first
    function automatic logic [WIDTH-1:0] mod_halve(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        if (x[0]) begin
            s = {1'b0, x} + QX[WIDTH:0];
        end else begin
            s = {1'b0, x};
        end
        return s[WIDTH:1];
    endfunction

    // Control travelling with the data: index n = after register stage n
    logic [6:1]       vld_r;
    logic [6:1]       mode_r;
    logic [6:1]       halve_r;

    logic [WIDTH-1:0] a1_r, b1_r, w1_r;
    logic [WIDTH-1:0] x2_r, w2_r;
    logic [WIDTH-1:0] keep_r [2:6];
    logic [2*WIDTH-1:0] p3_r;
    logic [WIDTH+1:0] p4_r;
    logic [WIDTH:0]   qh4_r;
    logic [WIDTH+1:0] r5_r;
    logic [WIDTH-1:0] m6_r;

    logic [WIDTH-1:0] oa_r [0:EXTRA_PIPE];
    logic [WIDTH-1:0] ob_r [0:EXTRA_PIPE];
    logic [EXTRA_PIPE:0] ov_r;

    logic [WIDTH-1:0]     add2_s, sub2_s, x2_s, k2_s;
    logic [WIDTH:0]       t4_s;
    logic [2*WIDTH+1:0]   prod4_s;
    logic [WIDTH+1:0]     qq5_s, r5_s;
    logic [WIDTH+1:0]     red1_s, red2_s;
    logic [WIDTH-1:0]     pa7_s, pb7_s, fa7_s, fb7_s;
    logic                 unused_bits_s;

    assign unused_bits_s = ^{prod4_s[WIDTH:0], red2_s[WIDTH+1:WIDTH]};

    // Shift valid/mode/halve alongside their data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r   <= 6'd0;
            mode_r  <= 6'd0;
            halve_r <= 6'd0;
        end else if (ce) begin
            vld_r   <= {vld_r[5:1], in_valid};
            mode_r  <= {mode_r[5:1], mode};
            halve_r <= {halve_r[5:1], halve};
        end
    end

    // Stage 1: input operand register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_r <= '0;
            b1_r <= '0;
            w1_r <= '0;
        end else if (ce) begin
            a1_r <= A;
            b1_r <= B;
            w1_r <= w;
        end
    end

    // Stage 2 operand select: GS pre-add/sub, CT pass-through
    always_comb begin
        add2_s = mod_add(a1_r, b1_r);
        sub2_s = mod_sub(a1_r, b1_r);
        if (mode_r[1]) begin
            x2_s = sub2_s;
            k2_s = add2_s;
        end else begin
            x2_s = b1_r;
            k2_s = a1_r;
        end
    end

    // Stage 2 register and the delay line for the non-multiplied operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x2_r <= '0;
            w2_r <= '0;
            for (int i = 2; i <= 6; i++) begin
                keep_r[i] <= '0;
            end
        end else if (ce) begin
            x2_r      <= x2_s;
            w2_r      <= w1_r;
            keep_r[2] <= k2_s;
            for (int i = 3; i <= 6; i++) begin
                keep_r[i] <= keep_r[i-1];
            end
        end
    end

    // Barrett quotient estimate and remainder before final correction
    always_comb begin
        t4_s    = p3_r[2*WIDTH-1:WIDTH-1];
        prod4_s = {{(WIDTH+1){1'b0}}, t4_s} * {{(WIDTH+1){1'b0}}, MU};
        qq5_s   = {1'b0, qh4_r} * QX;
        r5_s    = p4_r - qq5_s;
    end

    // Remainder is below 3Q: at most two subtractions bring it below Q
    always_comb begin
        if (r5_r >= QX) begin
            red1_s = r5_r - QX;
        end else begin
            red1_s = r5_r;
        end
        if (red1_s >= QX) begin
            red2_s = red1_s - QX;
        end else begin
            red2_s = red1_s;
        end
    end

    // Stages 3-6: product, quotient estimate, remainder, correction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p3_r  <= '0;
            p4_r  <= '0;
            qh4_r <= '0;
            r5_r  <= '0;
            m6_r  <= '0;
        end else if (ce) begin
            p3_r  <= {{WIDTH{1'b0}}, x2_r} * {{WIDTH{1'b0}}, w2_r};
            p4_r  <= p3_r[WIDTH+1:0];
            qh4_r <= prod4_s[2*WIDTH+1:WIDTH+1];
            r5_r  <= r5_s;
            m6_r  <= red2_s[WIDTH-1:0];
        end
    end

    // Stage 7 datapath: CT post-add/sub, then optional halving
    always_comb begin
        if (mode_r[6]) begin
            pa7_s = keep_r[6];
            pb7_s = m6_r;
        end else begin
            pa7_s = mod_add(keep_r[6], m6_r);
            pb7_s = mod_sub(keep_r[6], m6_r);
        end
        if (halve_r[6]) begin
            fa7_s = mod_halve(pa7_s);
            fb7_s = mod_halve(pb7_s);
        end else begin
            fa7_s = pa7_s;
            fb7_s = pb7_s;
        end
    end

    // Output register plus optional retiming stages; data only moves with a
    // valid result so a/b hold the last result across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_r <= '0;
            for (int i = 0; i <= EXTRA_PIPE; i++) begin
                oa_r[i] <= '0;
                ob_r[i] <= '0;
            end
        end else if (ce) begin
            ov_r[0] <= vld_r[6];
            if (vld_r[6]) begin
                oa_r[0] <= fa7_s;
                ob_r[0] <= fb7_s;
            end
            for (int i = 1; i <= EXTRA_PIPE; i++) begin
                ov_r[i] <= ov_r[i-1];
                if (ov_r[i-1]) begin
                    oa_r[i] <= oa_r[i-1];
                    ob_r[i] <= ob_r[i-1];
                end
            end
        end
    end

    assign out_valid = ov_r[EXTRA_PIPE];
    assign a         = oa_r[EXTRA_PIPE];
    assign b         = ob_r[EXTRA_PIPE];

endmodule

// File: tb/tb_ntt_butterfly_unified.sv
// Bench for ntt_butterfly_unified: lane 0 is the default build (latency 7),
// lane 1 the EXTRA_PIPE=2 build (latency 9), both fed the same stimulus.
module tb_ntt_butterfly_unified;

    localparam int          W  = 30;
    localparam int unsigned QV = 998244353;
    localparam logic [W-1:0] QM1 = 30'd998244352;

    logic         clk;
    logic         rst_n;
    logic         ce;
    logic         in_valid;
    logic         mode;
    logic         halve;
    logic [W-1:0] A, B, w;
    logic         ov0, ov1;
    logic [W-1:0] a0, b0, a1, b1;

    ntt_butterfly_unified #(.WIDTH(W), .Q(QV), .EXTRA_PIPE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
        .halve(halve), .A(A), .B(B), .w(w), .out_valid(ov0), .a(a0), .b(b0));

    ntt_butterfly_unified #(.WIDTH(W), .Q(QV), .EXTRA_PIPE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
        .halve(halve), .A(A), .B(B), .w(w), .out_valid(ov1), .a(a1), .b(b1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        int           base;
        logic         chk;
    } exp_t;

    typedef struct {
        logic         m;
        logic         h;
        logic [W-1:0] ia;
        logic [W-1:0] ib;
        logic [W-1:0] iw;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } vec_t;

    exp_t         sb[$];
    int           head [2];
    logic         prev_v [2];
    logic [W-1:0] prev_a [2];
    logic [W-1:0] prev_b [2];
    int           en_edges;
    logic         fresh;
    int           n_tests;
    int           n_fail;

    task automatic chk(input string name, input int l, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s lane%0d: got %0d, expected %0d", name, l, got, exp);
        end
    endtask

    // Golden model with plain 64-bit modular arithmetic
    task automatic model(input logic m, input logic h, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic [W-1:0] iw,
                         output logic [W-1:0] ea, output logic [W-1:0] eb);
        longint unsigned q, x, y, t;
        q = longint'(QV);
        if (m) begin
            x = (longint'(ia) + longint'(ib)) % q;
            y = (((longint'(ia) + q - longint'(ib)) % q) * longint'(iw)) % q;
        end else begin
            t = (longint'(ib) * longint'(iw)) % q;
            x = (longint'(ia) + t) % q;
            y = (longint'(ia) + q - t) % q;
        end
        if (h) begin
            x = (x % 2 == 0) ? x / 2 : (x + q) / 2;
            y = (y % 2 == 0) ? y / 2 : (y + q) / 2;
        end
        ea = x[W-1:0];
        eb = y[W-1:0];
    endtask

    // Drive one cycle of stimulus; queue an expectation when it will be taken
    task automatic drive(input logic v, input logic m, input logic h,
                         input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] iw, input logic c, input logic ck,
                         input logic [W-1:0] ea, input logic [W-1:0] eb);
        exp_t e;
        @(posedge clk);
        #1;
        ce = c; in_valid = v; mode = m; halve = h; A = ia; B = ib; w = iw;
        if (v && c) begin
            e.ea = ea; e.eb = eb; e.base = en_edges; e.chk = ck;
            sb.push_back(e);
        end
    endtask

    task automatic drive_rand(input logic m, input logic h);
        logic [W-1:0] ra, rb, rw, ea, eb;
        ra = W'($urandom_range(QV - 1, 0));
        rb = W'($urandom_range(QV - 1, 0));
        rw = W'($urandom_range(QV - 1, 0));
        model(m, h, ra, rb, rw, ea, eb);
        drive(1'b1, m, h, ra, rb, rw, 1'b1, 1'b1, ea, eb);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 30'd0, 30'd0, 30'd0, 1'b1, 1'b0, 30'd0, 30'd0);
    endtask

    task automatic check_lane(input int l, input int lat, input logic ov,
                              input logic [W-1:0] oa, input logic [W-1:0] ob);
        if (fresh) begin
            if (head[l] < sb.size() && sb[head[l]].base + lat == en_edges) begin
                chk("out_valid", l, longint'(ov), 64'd1);
                if (sb[head[l]].chk) begin
                    chk("a", l, longint'(oa), longint'(sb[head[l]].ea));
                    chk("b", l, longint'(ob), longint'(sb[head[l]].eb));
                end
                head[l]++;
            end else begin
                chk("no_spurious_valid", l, longint'(ov), 64'd0);
                chk("hold_ab", l, longint'({oa, ob}), longint'({prev_a[l], prev_b[l]}));
            end
        end else begin
            chk("stall_hold", l, longint'({ov, oa, ob}),
                longint'({prev_v[l], prev_a[l], prev_b[l]}));
        end
        prev_v[l] = ov;
        prev_a[l] = oa;
        prev_b[l] = ob;
    endtask

    // Count enabled edges; latency is measured in these
    always @(posedge clk) begin
        if (ce) begin
            en_edges <= en_edges + 1;
            fresh    <= 1'b1;
        end
    end

    // Output monitor for both lanes, away from the active edge
    always @(negedge clk) begin
        check_lane(0, 7, ov0, a0, b0);
        check_lane(1, 9, ov1, a1, b1);
        fresh <= 1'b0;
    end

    vec_t tbl [5];

    initial begin
        n_tests = 0; n_fail = 0; en_edges = 0; fresh = 1'b0;
        for (int l = 0; l < 2; l++) begin
            head[l] = 0; prev_v[l] = 1'b0; prev_a[l] = '0; prev_b[l] = '0;
        end
        rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; mode = 1'b0; halve = 1'b0;
        A = '0; B = '0; w = '0;

        tbl[0] = '{1'b1, 1'b0, 30'd5, 30'd3, 30'd2, 30'd8, 30'd4};
        tbl[1] = '{1'b0, 1'b0, 30'd5, 30'd3, 30'd2, 30'd11, QM1};
        tbl[2] = '{1'b1, 1'b1, 30'd4, 30'd3, 30'd2, 30'd499122180, 30'd1};
        tbl[3] = '{1'b1, 1'b0, QM1, 30'd1, 30'd1, 30'd0, 30'd998244351};
        tbl[4] = '{1'b1, 1'b0, QM1, 30'd0, QM1, QM1, 30'd1};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid0", 0, longint'(ov0), 64'd0);
        chk("rst_ab0", 0, longint'({a0, b0}), 64'd0);
        chk("rst_out_valid1", 1, longint'(ov1), 64'd0);
        #2 rst_n = 1'b1;

        // Directed vectors from the table, issued back to back
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, tbl[i].m, tbl[i].h, tbl[i].ia, tbl[i].ib, tbl[i].iw,
                  1'b1, 1'b1, tbl[i].ea, tbl[i].eb);
        end
        for (int i = 0; i < 10; i++) idle();

        // 64 back-to-back random ops, mode and halve changing every cycle
        for (int i = 0; i < 64; i++) begin
            drive_rand(i[0], i[1]);
        end
        for (int i = 0; i < 4; i++) idle();

        // Out-of-range operands, then a legal op that must still be right
        drive(1'b1, 1'b0, 1'b1, 30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF,
              1'b1, 1'b0, 30'd0, 30'd0);
        drive(1'b1, tbl[0].m, tbl[0].h, tbl[0].ia, tbl[0].ib, tbl[0].iw,
              1'b1, 1'b1, tbl[0].ea, tbl[0].eb);

        // Stall mid-stream: ce low for 3 cycles with junk on the inputs
        for (int i = 0; i < 9; i++) drive_rand(i[0], ~i[0]);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 30'd7, 30'd9, 30'd11, 1'b0, 1'b0, 30'd0, 30'd0);
        end
        for (int i = 0; i < 3; i++) drive_rand(~i[0], i[0]);
        for (int i = 0; i < 14; i++) idle();

        // Reset mid-stream with 4 ops in flight
        for (int i = 0; i < 4; i++) drive_rand(i[0], 1'b0);
        idle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_v0", 0, longint'(ov0), 64'd0);
        chk("midrst_ab0", 0, longint'({a0, b0}), 64'd0);
        chk("midrst_v1", 1, longint'(ov1), 64'd0);
        chk("midrst_ab1", 1, longint'({a1, b1}), 64'd0);
        for (int l = 0; l < 2; l++) begin
            head[l] = sb.size(); prev_v[l] = 1'b0; prev_a[l] = '0; prev_b[l] = '0;
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive(1'b1, tbl[1].m, tbl[1].h, tbl[1].ia, tbl[1].ib, tbl[1].iw,
              1'b1, 1'b1, tbl[1].ea, tbl[1].eb);
        idle();

        // Drain both lanes with a bounded wait
        for (int k = 0; k < 40 && !(head[0] == sb.size() && head[1] == sb.size()); k++) begin
            @(posedge clk);
        end
        chk("drain_lane0", 0, longint'(head[0]), longint'(sb.size()));
        chk("drain_lane1", 1, longint'(head[1]), longint'(sb.size()));
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
